// File: rtl/fm_nco_modulator.sv
// fm_nco_modulator
//   NCO-based FM modulator. A signed audio sample, scaled by dev_gain, is
//   added to the carrier frequency word. The phase accumulator is mapped
//   through a quarter-wave sine LUT, or a square wave in sq_mode. The
//   output comes from a 2-stage registered pipeline.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   enable       advance accumulator and launch a sample into the pipeline
//   sync_clr     synchronous clear of the accumulator (wins over enable)
//   sq_mode      0 = sine, 1 = square
//   carrier_fcw  unsigned carrier frequency control word
//   dev_gain     unsigned deviation gain
//   audio_in     signed audio sample  / audio_valid, audio_ready handshake
//   phase_out    accumulator value (debug)
//   fm_out       signed output sample / fm_valid marks a new sample
module fm_nco_modulator #(
  parameter int PHASE_W    = 24,
  parameter int AUDIO_W    = 12,
  parameter int OUT_W      = 12,
  parameter int LUT_ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sync_clr,
  input  logic               sq_mode,
  input  logic [PHASE_W-1:0] carrier_fcw,
  input  logic [7:0]         dev_gain,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic               audio_valid,
  output logic               audio_ready,
  output logic [PHASE_W-1:0] phase_out,
  output logic [OUT_W-1:0]   fm_out,
  output logic               fm_valid
);

  localparam int N      = 1 << LUT_ADDR_W;
  localparam int PROD_W = AUDIO_W + 9;

  typedef logic [OUT_W-2:0]        mag_t;
  typedef logic [N-1:0][OUT_W-2:0] lut_t;

  // Entries sample the centre of each bin, so none is zero and the
  // negated value always fits in OUT_W bits.
  function automatic lut_t build_lut();
    lut_t l;
    real  x;
    for (int i = 0; i < N; i++) begin
      x = real'((2 ** (OUT_W - 1)) - 1) *
          $sin(2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(4 * N));
      l[i] = mag_t'($rtoi(x + 0.5));
    end
    return l;
  endfunction

  localparam lut_t LUT     = build_lut();
  localparam mag_t FULL_SC = {(OUT_W-1){1'b1}};

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [AUDIO_W-1:0] audio_hold_q, audio_hold_d;
  logic               ready_q, ready_d;
  mag_t               mag1_q, mag1_d;
  logic               neg1_q, neg1_d;
  logic               sq1_q, sq1_d;
  logic               v1_q, v1_d;
  logic [OUT_W-1:0]   fm_out_q, fm_out_d;
  logic               fm_valid_q, fm_valid_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [PHASE_W-1:0] prod_ext;
  logic [PHASE_W-1:0]        inst_fcw;
  logic [1:0]                quad;
  logic [LUT_ADDR_W-1:0]     addr;
  logic signed [OUT_W-1:0]   mag_s;

  always_comb begin
    // dev_gain is zero-extended so the product stays signed.
    prod     = $signed(audio_hold_q) * $signed({1'b0, dev_gain});
    prod_ext = PHASE_W'(prod);
    inst_fcw = carrier_fcw + prod_ext;

    quad = phase_q[PHASE_W-1 -: 2];
    addr = phase_q[PHASE_W-3 -: LUT_ADDR_W];
    if (quad[0]) addr = ~addr;

    ready_d      = 1'b1;
    audio_hold_d = (audio_valid && ready_q) ? audio_in : audio_hold_q;

    phase_d = phase_q;
    if (sync_clr)    phase_d = '0;
    else if (enable) phase_d = phase_q + inst_fcw;

    // S1 captures only when a sample is launched; v1 drops when enable is low.
    // The sign for square mode is the phase MSB, which is also quad[1].
    mag1_d = mag1_q;
    neg1_d = neg1_q;
    sq1_d  = sq1_q;
    v1_d   = enable;
    if (enable) begin
      mag1_d = LUT[addr];
      neg1_d = quad[1];
      sq1_d  = sq_mode;
    end

    mag_s      = $signed({1'b0, sq1_q ? FULL_SC : mag1_q});
    fm_valid_d = v1_q;
    fm_out_d   = fm_out_q;
    if (v1_q) fm_out_d = neg1_q ? -mag_s : mag_s;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q      <= '0;
      audio_hold_q <= '0;
      ready_q      <= 1'b0;
      mag1_q       <= '0;
      neg1_q       <= 1'b0;
      sq1_q        <= 1'b0;
      v1_q         <= 1'b0;
      fm_out_q     <= '0;
      fm_valid_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      audio_hold_q <= audio_hold_d;
      ready_q      <= ready_d;
      mag1_q       <= mag1_d;
      neg1_q       <= neg1_d;
      sq1_q        <= sq1_d;
      v1_q         <= v1_d;
      fm_out_q     <= fm_out_d;
      fm_valid_q   <= fm_valid_d;
    end
  end

  assign audio_ready = ready_q;
  assign phase_out   = phase_q;
  assign fm_out      = fm_out_q;
  assign fm_valid    = fm_valid_q;

endmodule

// File: tb/tb_fm_nco_modulator.sv
module tb_fm_nco_modulator;

  logic        clk = 1'b0;
  logic        reset, enable, sync_clr, sq_mode, audio_valid;
  logic [23:0] carrier_fcw;
  logic [7:0]  dev_gain;
  logic [11:0] audio_in;
  logic        audio_ready, fm_valid;
  logic [23:0] phase_out;
  logic [11:0] fm_out;

  int n_cmp = 0;
  int n_err = 0;

  fm_nco_modulator dut (
    .clk(clk), .reset(reset), .enable(enable), .sync_clr(sync_clr),
    .sq_mode(sq_mode), .carrier_fcw(carrier_fcw), .dev_gain(dev_gain),
    .audio_in(audio_in), .audio_valid(audio_valid), .audio_ready(audio_ready),
    .phase_out(phase_out), .fm_out(fm_out), .fm_valid(fm_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int so(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  // Expected outputs for phases 0, 0x400000, 0x800000 and 0xC00000.
  int sine_q[4] = '{6, 2047, -6, -2047};
  int sq_q[4]   = '{2047, 2047, -2047, -2047};

  initial begin
    reset = 1'b0; enable = 1'b1; sync_clr = 1'b0; sq_mode = 1'b0;
    carrier_fcw = 24'h123456; dev_gain = 8'd77; audio_in = 12'h5A5; audio_valid = 1'b1;

    // 1. reset with busy inputs
    for (int i = 0; i < 3; i++) begin
      audio_in = 12'($urandom); carrier_fcw = 24'($urandom); sq_mode = 1'($urandom);
      step();
    end
    chk("rst_fm_out", so(fm_out), 0);
    chk("rst_fm_valid", int'(fm_valid), 0);
    chk("rst_ready", int'(audio_ready), 0);
    chk("rst_phase", int'(phase_out), 0);

    // Release with audio_valid low, so audio_hold stays 0.
    reset = 1'b1; enable = 1'b0; sync_clr = 1'b1; sq_mode = 1'b0;
    audio_valid = 1'b0; dev_gain = 8'd0; carrier_fcw = 24'h400000;
    step();
    chk("ready_after_rel", int'(audio_ready), 1);
    chk("phase_after_clr", int'(phase_out), 0);

    // 2. quadrant sweep
    sync_clr = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("sweep_phase", int'(phase_out), (k * 32'h400000) & 32'hFFFFFF);
      if (k == 1) chk("sweep_valid0", int'(fm_valid), 0);
      else begin
        chk("sweep_valid", int'(fm_valid), 1);
        chk("sweep_out", so(fm_out), sine_q[(k - 2) % 4]);
      end
    end

    // 3. deviation: +100 * 16
    enable = 1'b0; sync_clr = 1'b1; carrier_fcw = 24'h010000;
    audio_in = 12'd100; dev_gain = 8'd16; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0; sync_clr = 1'b0; enable = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("dev_pos_phase", int'(phase_out), 32'h0A3E80);
    // -2048 * 255, frequency word wraps
    enable = 1'b0; sync_clr = 1'b1; audio_in = 12'h800; dev_gain = 8'd255; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0; sync_clr = 1'b0; enable = 1'b1;
    step();
    chk("dev_neg_phase", int'(phase_out), 32'hF90800);

    // 4. wrap and clear (dev_gain 0 cancels the held -2048)
    dev_gain = 8'd0; carrier_fcw = 24'h800000; enable = 1'b0; sync_clr = 1'b1;
    step();
    sync_clr = 1'b0; enable = 1'b1;
    step(); chk("wrap_p1", int'(phase_out), 32'h800000);
    step(); chk("wrap_p2", int'(phase_out), 0);
    step(); chk("wrap_p3", int'(phase_out), 32'h800000);
    sync_clr = 1'b1;
    step();
    chk("clr_phase", int'(phase_out), 0);
    chk("clr_prev_out", so(fm_out), 6);
    sync_clr = 1'b0; enable = 1'b0;
    step();
    chk("clr_sample", so(fm_out), -6);
    chk("clr_sample_vld", int'(fm_valid), 1);
    chk("clr_hold_phase", int'(phase_out), 0);
    step();
    chk("clr_vld_drop", int'(fm_valid), 0);
    chk("clr_out_hold", so(fm_out), -6);

    // 5. enable gating 1,0,0,1,0,0
    carrier_fcw = 24'h400000;
    enable = 1'b1; step();
    chk("gate1_phase", int'(phase_out), 32'h400000);
    chk("gate1_vld", int'(fm_valid), 0);
    chk("gate1_out", so(fm_out), -6);
    enable = 1'b0; step();
    chk("gate2_phase", int'(phase_out), 32'h400000);
    chk("gate2_vld", int'(fm_valid), 1);
    chk("gate2_out", so(fm_out), 6);
    step();
    chk("gate3_phase", int'(phase_out), 32'h400000);
    chk("gate3_vld", int'(fm_valid), 0);
    chk("gate3_out", so(fm_out), 6);
    enable = 1'b1; step();
    chk("gate4_phase", int'(phase_out), 32'h800000);
    chk("gate4_vld", int'(fm_valid), 0);
    chk("gate4_out", so(fm_out), 6);
    enable = 1'b0; step();
    chk("gate5_vld", int'(fm_valid), 1);
    chk("gate5_out", so(fm_out), 2047);
    step();
    chk("gate6_vld", int'(fm_valid), 0);
    chk("gate6_out", so(fm_out), 2047);

    // 6. square mode, then reset mid-stream
    sync_clr = 1'b1; step();
    sync_clr = 1'b0; enable = 1'b1; sq_mode = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k >= 2) begin
        chk("sq_valid", int'(fm_valid), 1);
        chk("sq_out", so(fm_out), sq_q[(k - 2) % 4]);
      end
    end
    reset = 1'b0; step();
    chk("mid_rst_out", so(fm_out), 0);
    chk("mid_rst_vld", int'(fm_valid), 0);
    chk("mid_rst_ready", int'(audio_ready), 0);
    chk("mid_rst_phase", int'(phase_out), 0);
    reset = 1'b1; enable = 1'b0; step();
    chk("rel_vld", int'(fm_valid), 0);
    chk("rel_out", so(fm_out), 0);
    chk("rel_ready", int'(audio_ready), 1);
    step();
    chk("rel_vld2", int'(fm_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
